// File: rtl/sync_sched_pkg.sv
// Shared definitions for the sync_scheduler crossing-bus arbiter.
// Optional fixed priority for requester 0 is enabled by defining SYNC_SCHED_PRIO0_EN.
package sync_sched_pkg;

    localparam int HOLD_MIN = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_sched_rr_pick.sv
// Combinational round-robin winner selection with optional requester-0 priority.
module sync_sched_rr_pick
    import sync_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_winner,
    input  logic           prio0_en,
    output logic [IDW-1:0] winner,
    output logic           valid
);

    // Scan from last_winner+1 upward with wrap; the first requester found wins.
    always_comb begin
        winner = {IDW{1'b0}};
        valid  = 1'b0;
        if (prio0_en && req[0]) begin
            winner = {IDW{1'b0}};
            valid  = 1'b1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                winner = (!valid && req[(int'(last_winner) + k) % N]) ?
                         IDW'((int'(last_winner) + k) % N) : winner;
                valid  = valid | req[(int'(last_winner) + k) % N];
            end
        end
    end

endmodule

// File: rtl/sync_scheduler.sv
// Arbitrates N requesters onto one toggle-tagged crossing word with a minimum HOLD spacing.
// Define SYNC_SCHED_PRIO0_EN to give requester 0 fixed priority over the round-robin.
module sync_scheduler
    import sync_sched_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 32,
    parameter  int HOLD = 8,
    localparam int IDW  = clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     gnt,
    output logic [IDW+W:0]   xbus,
    output logic             busy
);

`ifdef SYNC_SCHED_PRIO0_EN
    localparam logic PRIO0_EN = 1'b1;
`else
    localparam logic PRIO0_EN = 1'b0;
`endif

    state_t          state_r;
    logic [7:0]      cnt_r;
    logic [N-1:0]    gnt_r;
    logic            busy_r;
    logic            tgl_r;
    logic [IDW-1:0]  id_r;
    logic [W-1:0]    data_r;
    logic [IDW-1:0]  last_winner_r;

    logic [IDW-1:0]  win_s;
    logic            win_valid_s;
    logic [W-1:0]    win_data_s;
    logic [N-1:0]    win_onehot_s;

    sync_sched_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req         (req),
        .last_winner (last_winner_r),
        .prio0_en    (PRIO0_EN),
        .winner      (win_s),
        .valid       (win_valid_s)
    );

    assign win_data_s   = req_data[int'(win_s)*W +: W];
    assign win_onehot_s = {{(N-1){1'b0}}, 1'b1} << win_s;

    assign gnt  = gnt_r;
    assign busy = busy_r;
    assign xbus = {tgl_r, id_r, data_r};

    // Grant FSM: one arbitration in IDLE, then HOLD cycles before the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            gnt_r         <= {N{1'b0}};
            busy_r        <= 1'b0;
            tgl_r         <= 1'b0;
            id_r          <= {IDW{1'b0}};
            data_r        <= {W{1'b0}};
            last_winner_r <= IDW'(N - 1);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        gnt_r   <= win_onehot_s;
                        tgl_r   <= ~tgl_r;
                        id_r    <= win_s;
                        data_r  <= win_data_s;
                        state_r <= ST_HOLD;
                        busy_r  <= 1'b1;
                        cnt_r   <= 8'(HOLD - HOLD_MIN);
                        // Priority grants to requester 0 must not disturb the rotation of 1..N-1.
                        if (!(PRIO0_EN && (win_s == {IDW{1'b0}}))) begin
                            last_winner_r <= win_s;
                        end else begin
                            last_winner_r <= last_winner_r;
                        end
                    end else begin
                        gnt_r <= {N{1'b0}};
                    end
                end
                ST_HOLD: begin
                    gnt_r <= {N{1'b0}};
                    if (cnt_r == 8'd0) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 8'd0;
                    gnt_r   <= {N{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sync_scheduler.md
SYNC_SCHEDULER -- requirements
Module: sync_scheduler

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one crossing bus (2..16).
REQ-002 Parameter W, default 32: data width per requester.
REQ-003 Parameter HOLD, default 8: minimum cycles between consecutive xbus updates (legal range 2..255).
REQ-004 Derived IDW = clog2(N): requester-id width.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 req  in  N  per-requester level request; bit i held high until gnt[i].
REQ-008 req_data  in  N*W  requester i payload in bits [i*W +: W]; stable while req[i] is high.
REQ-009 gnt  out  N  one-cycle, one-hot grant/acknowledge pulse.
REQ-010 xbus  out  1+IDW+W  crossing word {tgl, id, data}; fed to a change-detect clock-domain crossing.
REQ-011 busy  out  1  high while in HOLD.

Function
REQ-012 FSM states: IDLE, HOLD; encoding from the shared package.
REQ-013 IDLE, edge t, req!=0: pick one winner w; at t+1, xbus.data=req_data[w], xbus.id=w, xbus.tgl inverted, gnt[w]=1, state=HOLD, cnt=HOLD-2.
REQ-014 IDLE, req==0: no change; gnt=0.
REQ-015 HOLD: gnt=0; cnt decrements each cycle; cnt==0 -> IDLE on next edge; req ignored.
REQ-016 Update spacing: consecutive xbus changes exactly HOLD cycles apart under continuous request; never fewer.
REQ-017 xbus changes only in the cycle gnt pulses; otherwise it holds its value.
REQ-018 Round-robin: search starts at last_winner+1 mod N, increasing index, wraps at N-1 -> 0; last_winner updated on every grant.
REQ-019 tgl inverts on every grant so that identical consecutive {id, data} still yields a changed xbus word.
REQ-020 req[i] still high in the cycle after gnt[i] counts as a new request.
REQ-021 req[i] dropped before its grant: that request is discarded silently; no gnt[i].
REQ-022 Simultaneous requests: exactly one grant per arbitration; the others wait and are neither lost nor reordered beyond round-robin order.
REQ-023 Worst-case grant latency for a held request: N*HOLD cycles.

Reset
REQ-024 rst at edge -> next cycle: state=IDLE, cnt=0, gnt=0, busy=0, xbus=0 (tgl=0), last_winner=N-1.
REQ-025 rst mid-HOLD aborts the hold; the first post-reset arbitration is allowed in the cycle after rst deasserts.
REQ-026 No output depends combinationally on rst.

Configuration
REQ-027 Macro SYNC_SCHED_PRIO0_EN defined: requester 0 wins whenever req[0]=1; round-robin applies among 1..N-1; last_winner unchanged by grants to requester 0.
REQ-028 Macro not defined: pure round-robin over 0..N-1 per REQ-018.

Structure
REQ-029 Package sync_sched_pkg: FSM state constants, clog2 function, HOLD_MIN=2.
REQ-030 One sub-module sync_sched_rr_pick: combinational round-robin winner and valid from req, last_winner, and the prio0 enable.
REQ-031 xbus, gnt, state, cnt, last_winner, tgl are registers; no latches.

Verification
REQ-032 Single request, N=4, HOLD=8: req[2]=1, data=0xDEADBEEF at t -> t+1 gnt=0100, xbus={1,2,0xDEADBEEF}, busy high for t+1..t+7.
REQ-033 Four requests held high from reset -> grants in order 0,1,2,3,0, spaced 8 cycles apart; tgl alternates 1,0,1,0,1.
REQ-034 Requester 1 sends 0x5 twice -> two xbus changes differing only in tgl; downstream crossing latches both.
REQ-035 req[3] pulses for 3 cycles while in HOLD, then drops -> no gnt[3]; xbus unchanged.
REQ-036 rst asserted at HOLD cnt=3 -> next cycle xbus=0, busy=0; pending req[1] is granted 2 cycles after rst deasserts.
REQ-037 SYNC_SCHED_PRIO0_EN defined, req=1111 held -> grant order 0,0,0,... with no grants to 1..3; drop req[0] -> order 1,2,3.
